eq_stream_miter: RTL and testbench
==================================

# eq_stream_miter

Parametrised miter controller for equivalence checking of two stream-producing models (A = high-level ILA, B = detailed ILA). It replaces per-model clock gating with step enables, buffers each model's output stream in its own FIFO so that A and B may emit beats on different cycles, compares beats pairwise in order, and reports PASS, FAIL (data or length mismatch) or TIMEOUT through a phase FSM. It sits between the two model instances and the property checker, one level below the equivalence top.

## Interface

Parameters:
- DATA_W, 8, stream beat width in bits
- DEPTH, 4, per-side FIFO depth in beats; power of two, ≥ 2
- CNT_W, 16, width of cycle counter and match counter
- BOUND, 15, RUN-phase cycle budget before TIMEOUT; 1 ≤ BOUND < 2^CNT_W

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  arm/re-arm pulse
- a_complete  in  1  model A finished
- b_complete  in  1  model B finished
- a_tdata  in  DATA_W  model A output beat
- a_tvalid  in  1  model A beat valid
- a_tready  out  1  miter accepts A beat
- b_tdata  in  DATA_W  model B output beat
- b_tvalid  in  1  model B beat valid
- b_tready  out  1  miter accepts B beat
- a_step  out  1  step enable to model A
- b_step  out  1  step enable to model B
- phase  out  3  0 IDLE, 1 RUN, 2 DRAIN, 3 PASS, 4 FAIL, 5 TIMEOUT
- mismatch  out  1  sticky: data or length mismatch seen
- len_err  out  1  sticky: FAIL caused by unequal beat counts
- fail_a, fail_b  out  DATA_W  heads captured at first data mismatch
- matched  out  CNT_W  beats compared equal, saturating
- cycles  out  CNT_W  cycles spent in RUN, saturating at BOUND

## Operation

- Reset: phase=IDLE; FIFOs empty; all outputs 0.
- Push: side X pushes when X_tvalid & X_tready. X_tready = (phase==RUN | phase==DRAIN) & !X_full. Push into a full FIFO is impossible by construction.
- Step: X_step = (phase==RUN) & !X_complete & !X_full; the faster model stalls when its FIFO is full.
- Compare: when both FIFOs are non-empty (registered state), both heads pop on the same edge; the comparison result is registered on that edge. Equal → matched+1 (saturate at 2^CNT_W−1). Unequal → mismatch=1, fail_a/fail_b latched, phase→FAIL.
- FSM:
  - IDLE: start → RUN (clears FIFOs, counters, flags).
  - RUN: cycles+1 each cycle, saturating at BOUND. a_complete & b_complete → DRAIN. cycles==BOUND with no completion → TIMEOUT.
  - DRAIN: models are no longer stepped, tready is still high. Both FIFOs empty → PASS. Exactly one empty, the other non-empty, and no push that cycle → FAIL with len_err=1, mismatch=1.
  - PASS/FAIL/TIMEOUT: hold; start → RUN with full clear.
- Priority on one edge: data mismatch > completion > timeout. Completion and timeout on the same edge → DRAIN. start outside IDLE and terminal states is ignored.
- Simultaneous push and pop on one side: occupancy unchanged; data order preserved.
- Pointers wrap modulo DEPTH; occupancy needs log2(DEPTH)+1 bits.

## Timing

- start at edge k: phase=RUN and steps asserted after k.
- Beat pushed at edge k into empty FIFOs on both sides: popped at edge k+1; matched/mismatch/phase updated after k+1. Input-to-verdict latency is 2 cycles.
- FIFO full is visible in X_tready/X_step the cycle after the filling push (registered occupancy).
- rst asserted mid-operation clears all state immediately, regardless of clk.

## Test plan

- A and B each emit 0x11, 0x22, 0x33 on identical cycles, then complete → matched=3, phase DRAIN then PASS, mismatch=0.
- B lags A by 3 cycles with DEPTH=4, identical data → a_step drops once A's FIFO holds 4 beats; no beat lost; PASS with matched equal to beat count.
- Third beat is A=0x33, B=0x34 → phase=FAIL 2 cycles after that beat, fail_a=0x33, fail_b=0x34, matched=2.
- A emits 4 beats, B emits 3, both complete → DRAIN, then FAIL with len_err=1, matched=3.
- Neither side completes, BOUND=15 → phase=TIMEOUT after 15 RUN cycles, cycles=15. start then re-arms to RUN with cycles=0.
- rst pulsed mid-RUN between clock edges → phase=0, all outputs 0 immediately. A later start runs cleanly.

Source files
------------

// File: rtl/eq_stream_miter.sv
// ---------------------------------------------------------------------------
// eq_stream_miter
//
// Miter controller that checks two stream-producing models for equivalence.
// Model A is the high-level ILA and model B is the detailed ILA. Each model is
// advanced by a step enable. Each model's output beats go into their own FIFO,
// so A and B may emit a given beat on different cycles. The two FIFO heads are
// compared pairwise and in order. A phase FSM reports PASS, FAIL (data or
// length mismatch) or TIMEOUT.
//
// Parameters:
//   DATA_W  beat width
//   DEPTH   per-side FIFO depth in beats (power of two, >= 2)
//   CNT_W   width of the cycle and match counters
//   BOUND   RUN-phase cycle budget before TIMEOUT (1 <= BOUND < 2^CNT_W)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    arm / re-arm pulse (honoured in IDLE and terminal phases)
//   a_complete, b_complete   model finished indications
//   a_tdata/a_tvalid/a_tready
//   b_tdata/b_tvalid/b_tready  per-side beat handshakes into the FIFOs
//   a_step, b_step           step enables to the models
//   phase                    0 IDLE, 1 RUN, 2 DRAIN, 3 PASS, 4 FAIL, 5 TIMEOUT
//   mismatch                 sticky, data or length mismatch seen
//   len_err                  sticky, FAIL caused by unequal beat counts
//   fail_a, fail_b           FIFO heads captured at the data mismatch
//   matched                  beats compared equal (saturating)
//   cycles                   cycles spent in RUN (saturating at BOUND)
// ---------------------------------------------------------------------------
module eq_stream_miter #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16,
   parameter int BOUND  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              a_complete,
   input  logic              b_complete,
   input  logic [DATA_W-1:0] a_tdata,
   input  logic              a_tvalid,
   output logic              a_tready,
   input  logic [DATA_W-1:0] b_tdata,
   input  logic              b_tvalid,
   output logic              b_tready,
   output logic              a_step,
   output logic              b_step,
   output logic [2:0]        phase,
   output logic              mismatch,
   output logic              len_err,
   output logic [DATA_W-1:0] fail_a,
   output logic [DATA_W-1:0] fail_b,
   output logic [CNT_W-1:0]  matched,
   output logic [CNT_W-1:0]  cycles
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] BOUND_C  = CNT_W'(BOUND);
   localparam logic [CNT_W-1:0] BOUND_M1 = CNT_W'(BOUND - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      PH_IDLE    = 3'd0,
      PH_RUN     = 3'd1,
      PH_DRAIN   = 3'd2,
      PH_PASS    = 3'd3,
      PH_FAIL    = 3'd4,
      PH_TIMEOUT = 3'd5
   } phase_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
      return (v >= lim) ? v : v + 1'b1;
   endfunction

   phase_t state_q, state_d;

   logic [DATA_W-1:0] mem_a [DEPTH];
   logic [DATA_W-1:0] mem_b [DEPTH];
   logic [AW-1:0]     wr_a, rd_a, wr_b, rd_b;
   logic [AW:0]       occ_a, occ_b;

   logic              active, arm;
   logic              a_full, b_full, a_empty, b_empty;
   logic              push_a, push_b;
   logic              len_fail;

   // Stage p0: FIFO heads presented to the comparator
   logic [DATA_W-1:0] head_a_p0, head_b_p0;
   logic              vld_p0, ne_p0, data_miss_p0;

   assign active  = (state_q == PH_RUN) || (state_q == PH_DRAIN);
   // start is ignored while RUN/DRAIN; any other phase re-arms with a full clear
   assign arm     = start && !active;

   assign a_full  = (occ_a == OCC_FULL);
   assign b_full  = (occ_b == OCC_FULL);
   assign a_empty = (occ_a == '0);
   assign b_empty = (occ_b == '0);

   assign a_tready = active && !a_full;
   assign b_tready = active && !b_full;
   assign push_a   = a_tvalid && a_tready;
   assign push_b   = b_tvalid && b_tready;

   // The faster model stalls while its FIFO is full
   assign a_step = (state_q == PH_RUN) && !a_complete && !a_full;
   assign b_step = (state_q == PH_RUN) && !b_complete && !b_full;

   assign head_a_p0    = mem_a[rd_a];
   assign head_b_p0    = mem_b[rd_b];
   assign vld_p0       = active && !a_empty && !b_empty;
   assign ne_p0        = (head_a_p0 != head_b_p0);
   assign data_miss_p0 = vld_p0 && ne_p0;

   assign phase = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= PH_IDLE;
      else     state_q <= state_d;
   end

   // Priority within a phase: data mismatch, then completion, then timeout
   always_comb begin
      state_d  = state_q;
      len_fail = 1'b0;
      case (state_q)
         PH_IDLE, PH_PASS, PH_FAIL, PH_TIMEOUT: begin
            if (start) state_d = PH_RUN;
         end
         PH_RUN: begin
            if (data_miss_p0)                  state_d = PH_FAIL;
            else if (a_complete && b_complete) state_d = PH_DRAIN;
            else if (cycles == BOUND_M1)       state_d = PH_TIMEOUT;
         end
         PH_DRAIN: begin
            if (data_miss_p0) begin
               state_d = PH_FAIL;
            end else if (a_empty && b_empty) begin
               state_d = PH_PASS;
            end else if ((a_empty != b_empty) && !push_a && !push_b) begin
               // One side has leftover beats that can never be paired
               state_d  = PH_FAIL;
               len_fail = 1'b1;
            end
         end
         default: state_d = PH_IDLE;
      endcase
   end

   // FIFO storage carries no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push_a) mem_a[wr_a] <= a_tdata;
      if (push_b) mem_b[wr_b] <= b_tdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_a  <= '0;
         rd_a  <= '0;
         occ_a <= '0;
         wr_b  <= '0;
         rd_b  <= '0;
         occ_b <= '0;
      end else if (arm) begin
         wr_a  <= '0;
         rd_a  <= '0;
         occ_a <= '0;
         wr_b  <= '0;
         rd_b  <= '0;
         occ_b <= '0;
      end else begin
         if (push_a) wr_a <= wr_a + 1'b1;
         if (push_b) wr_b <= wr_b + 1'b1;
         if (vld_p0) begin
            rd_a <= rd_a + 1'b1;
            rd_b <= rd_b + 1'b1;
         end
         // Simultaneous push and pop leaves occupancy unchanged
         case ({push_a, vld_p0})
            2'b10:   occ_a <= occ_a + 1'b1;
            2'b01:   occ_a <= occ_a - 1'b1;
            default: occ_a <= occ_a;
         endcase
         case ({push_b, vld_p0})
            2'b10:   occ_b <= occ_b + 1'b1;
            2'b01:   occ_b <= occ_b - 1'b1;
            default: occ_b <= occ_b;
         endcase
      end
   end

   // Stage p1: registered comparison results and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         matched  <= '0;
         cycles   <= '0;
         mismatch <= 1'b0;
         len_err  <= 1'b0;
         fail_a   <= '0;
         fail_b   <= '0;
      end else if (arm) begin
         matched  <= '0;
         cycles   <= '0;
         mismatch <= 1'b0;
         len_err  <= 1'b0;
         fail_a   <= '0;
         fail_b   <= '0;
      end else begin
         if (state_q == PH_RUN) cycles <= sat_inc(cycles, BOUND_C);
         if (vld_p0 && !ne_p0)  matched <= sat_inc(matched, CNT_MAX);
         if (data_miss_p0) begin
            mismatch <= 1'b1;
            fail_a   <= head_a_p0;
            fail_b   <= head_b_p0;
         end
         if (len_fail) begin
            mismatch <= 1'b1;
            len_err  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_eq_stream_miter.sv
module tb_eq_stream_miter;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 16;
   localparam int BOUND  = 15;

   logic              clk = 1'b0;
   logic              rst, start, a_complete, b_complete;
   logic [DATA_W-1:0] a_tdata, b_tdata;
   logic              a_tvalid, b_tvalid, a_tready, b_tready, a_step, b_step;
   logic [2:0]        phase;
   logic              mismatch, len_err;
   logic [DATA_W-1:0] fail_a, fail_b;
   logic [CNT_W-1:0]  matched, cycles;

   eq_stream_miter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .BOUND(BOUND)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a_complete(a_complete), .b_complete(b_complete),
      .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
      .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready),
      .a_step(a_step), .b_step(b_step), .phase(phase),
      .mismatch(mismatch), .len_err(len_err),
      .fail_a(fail_a), .fail_b(fail_b),
      .matched(matched), .cycles(cycles)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef logic [DATA_W-1:0] beat_t;
   beat_t       a_src[$], b_src[$];   // beats each model will offer
   beat_t       a_acc[$], b_acc[$];   // beats the miter accepted
   logic [15:0] exp_q[$];             // expected compare pairs {a,b}, in order
   logic [16:0] obs_q[$];             // observed compares {is_miss, fail_a, fail_b}
   logic [15:0] e;
   logic [16:0] o;
   int          term_cyc, last_push_cyc;
   bit          saw_drain, a_stall_seen;

   // Arms the miter; returns at the negedge after the start edge.
   task automatic do_start();
      @(negedge clk);
      a_tvalid = 1'b0; b_tvalid = 1'b0;
      a_complete = 1'b0; b_complete = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Plays both model streams cycle by cycle, entered and left at a negedge.
   // Pushes an expected pair whenever both sides have a beat accepted at the
   // same index and records every compare the DUT reports.
   task automatic run_streams(input int a_delay, input int b_delay,
                              input int budget, input bit complete_en);
      int cyc, ia, ib, np;
      bit acc_a, acc_b, done;
      logic [CNT_W-1:0] m_prev;
      logic miss_prev;
      cyc = 0; ia = 0; ib = 0; np = 0; done = 0;
      m_prev = '0; miss_prev = 1'b0;
      saw_drain = 0; a_stall_seen = 0; term_cyc = -1; last_push_cyc = -1;
      a_acc.delete(); b_acc.delete(); exp_q.delete(); obs_q.delete();
      while (!done) begin
         if (matched != m_prev) begin
            obs_q.push_back({1'b0, 16'h0000});
            m_prev = matched;
         end
         if (mismatch && !miss_prev && !len_err) obs_q.push_back({1'b1, fail_a, fail_b});
         miss_prev = mismatch;
         if (phase >= 3'd3) begin
            term_cyc = cyc;
            done = 1;
         end else if (cyc >= budget) begin
            checks++; failures++;
            $display("FAIL run_budget phase=%0d after %0d cycles, required a terminal phase", phase, cyc);
            done = 1;
         end else begin
            if (phase == 3'd2) saw_drain = 1;
            if (phase == 3'd1 && !a_complete && !a_step) a_stall_seen = 1;
            a_tvalid   = (ia < a_src.size()) && (cyc >= a_delay);
            a_tdata    = a_tvalid ? a_src[ia] : '0;
            a_complete = complete_en && (ia == a_src.size());
            b_tvalid   = (ib < b_src.size()) && (cyc >= b_delay);
            b_tdata    = b_tvalid ? b_src[ib] : '0;
            b_complete = complete_en && (ib == b_src.size());
            acc_a = a_tvalid && a_tready;
            acc_b = b_tvalid && b_tready;
            @(posedge clk);
            cyc++;
            if (acc_a) begin a_acc.push_back(a_tdata); ia++; last_push_cyc = cyc; end
            if (acc_b) begin b_acc.push_back(b_tdata); ib++; last_push_cyc = cyc; end
            while (np < a_acc.size() && np < b_acc.size()) begin
               exp_q.push_back({a_acc[np], b_acc[np]});
               np++;
            end
            @(negedge clk);
         end
      end
      a_tvalid = 1'b0; b_tvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a_complete = 1'b0; b_complete = 1'b0;
      a_tvalid = 1'b0; b_tvalid = 1'b0; a_tdata = '0; b_tdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase); end
      checks++;
      if ({mismatch, len_err, fail_a, fail_b, matched, cycles, a_tready, b_tready, a_step, b_step} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got mm=%0b le=%0b fa=%0h fb=%0h m=%0d c=%0d rdy=%0b%0b step=%0b%0b exp all 0",
                  mismatch, len_err, fail_a, fail_b, matched, cycles, a_tready, b_tready, a_step, b_step);
      end
      rst = 1'b0;
   endtask

   task automatic test_identical();
      a_src = '{8'h11, 8'h22, 8'h33};
      b_src = '{8'h11, 8'h22, 8'h33};
      do_start();
      run_streams(0, 0, 30, 1'b1);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         checks++;
         if (exp_q.size() == 0) begin failures++; $display("FAIL ident_sb unexpected compare %0h", o); end
         else begin
            e = exp_q.pop_front();
            if (o[16] !== (e[15:8] != e[7:0])) begin
               failures++; $display("FAIL ident_sb pair=%0h got miss=%0b", e, o[16]);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL ident_sb_left got=%0d exp=0", exp_q.size()); end
      checks++;
      if (phase !== 3'd3) begin failures++; $display("FAIL ident_phase got=%0d exp=3", phase); end
      checks++;
      if (saw_drain !== 1'b1) begin failures++; $display("FAIL ident_drain got=%0b exp=1", saw_drain); end
      checks++;
      if (matched !== 16'd3) begin failures++; $display("FAIL ident_matched got=%0d exp=3", matched); end
      checks++;
      if (mismatch !== 1'b0) begin failures++; $display("FAIL ident_mismatch got=%0b exp=0", mismatch); end
      checks++;
      if (a_stall_seen !== 1'b0) begin failures++; $display("FAIL ident_nostall got=%0b exp=0", a_stall_seen); end
   endtask

   task automatic test_lag();
      beat_t v;
      a_src.delete(); b_src.delete();
      for (int i = 0; i < 6; i++) begin
         v = beat_t'($urandom_range(0, 255));
         a_src.push_back(v);
         b_src.push_back(v);
      end
      do_start();
      run_streams(0, 3, 50, 1'b1);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         checks++;
         if (exp_q.size() == 0) begin failures++; $display("FAIL lag_sb unexpected compare %0h", o); end
         else begin
            e = exp_q.pop_front();
            if (o[16] !== (e[15:8] != e[7:0])) begin
               failures++; $display("FAIL lag_sb pair=%0h got miss=%0b", e, o[16]);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL lag_sb_left got=%0d exp=0", exp_q.size()); end
      checks++;
      if (a_stall_seen !== 1'b1) begin failures++; $display("FAIL lag_a_step_drop got=%0b exp=1", a_stall_seen); end
      checks++;
      if (a_acc != a_src || b_acc != b_src) begin
         failures++; $display("FAIL lag_beats got a=%0d b=%0d accepted exp=6 each, in order", a_acc.size(), b_acc.size());
      end
      checks++;
      if (phase !== 3'd3) begin failures++; $display("FAIL lag_phase got=%0d exp=3", phase); end
      checks++;
      if (matched !== 16'd6) begin failures++; $display("FAIL lag_matched got=%0d exp=6", matched); end
   endtask

   task automatic test_data_mismatch();
      a_src = '{8'h11, 8'h22, 8'h33};
      b_src = '{8'h11, 8'h22, 8'h34};
      do_start();
      run_streams(0, 0, 30, 1'b1);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         checks++;
         if (exp_q.size() == 0) begin failures++; $display("FAIL miss_sb unexpected compare %0h", o); end
         else begin
            e = exp_q.pop_front();
            if (o[16] !== (e[15:8] != e[7:0])) begin
               failures++; $display("FAIL miss_sb pair=%0h got miss=%0b", e, o[16]);
            end else if (o[16] && o[15:0] !== e) begin
               failures++; $display("FAIL miss_sb_heads got=%0h exp=%0h", o[15:0], e);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL miss_sb_left got=%0d exp=0", exp_q.size()); end
      checks++;
      if (phase !== 3'd4) begin failures++; $display("FAIL miss_phase got=%0d exp=4", phase); end
      checks++;
      if (term_cyc != last_push_cyc + 1) begin
         failures++; $display("FAIL miss_latency got verdict at %0d exp %0d", term_cyc, last_push_cyc + 1);
      end
      checks++;
      if ({fail_a, fail_b} !== 16'h3334) begin failures++; $display("FAIL miss_heads got=%0h%0h exp=3334", fail_a, fail_b); end
      checks++;
      if (matched !== 16'd2) begin failures++; $display("FAIL miss_matched got=%0d exp=2", matched); end
      checks++;
      if ({mismatch, len_err} !== 2'b10) begin failures++; $display("FAIL miss_flags got mm=%0b le=%0b exp mm=1 le=0", mismatch, len_err); end
   endtask

   task automatic test_length();
      a_src = '{8'h11, 8'h22, 8'h33, 8'h44};
      b_src = '{8'h11, 8'h22, 8'h33};
      do_start();
      run_streams(0, 0, 30, 1'b1);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         checks++;
         if (exp_q.size() == 0) begin failures++; $display("FAIL len_sb unexpected compare %0h", o); end
         else begin
            e = exp_q.pop_front();
            if (o[16] !== (e[15:8] != e[7:0])) begin
               failures++; $display("FAIL len_sb pair=%0h got miss=%0b", e, o[16]);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL len_sb_left got=%0d exp=0", exp_q.size()); end
      checks++;
      if (saw_drain !== 1'b1) begin failures++; $display("FAIL len_drain got=%0b exp=1", saw_drain); end
      checks++;
      if (phase !== 3'd4) begin failures++; $display("FAIL len_phase got=%0d exp=4", phase); end
      checks++;
      if ({mismatch, len_err} !== 2'b11) begin failures++; $display("FAIL len_flags got mm=%0b le=%0b exp 1 1", mismatch, len_err); end
      checks++;
      if (matched !== 16'd3) begin failures++; $display("FAIL len_matched got=%0d exp=3", matched); end
      checks++;
      if ({fail_a, fail_b} !== 16'h0000) begin failures++; $display("FAIL len_heads got=%0h%0h exp=0000", fail_a, fail_b); end
   endtask

   task automatic test_timeout();
      a_src.delete(); b_src.delete();
      do_start();
      run_streams(0, 0, 40, 1'b0);
      checks++;
      if (phase !== 3'd5) begin failures++; $display("FAIL to_phase got=%0d exp=5", phase); end
      checks++;
      if (term_cyc != BOUND) begin failures++; $display("FAIL to_run_cycles got=%0d exp=%0d", term_cyc, BOUND); end
      checks++;
      if (cycles !== 16'(BOUND)) begin failures++; $display("FAIL to_cycles got=%0d exp=%0d", cycles, BOUND); end
      do_start();
      checks++;
      if (phase !== 3'd1) begin failures++; $display("FAIL to_rearm_phase got=%0d exp=1", phase); end
      checks++;
      if (cycles !== 16'd0) begin failures++; $display("FAIL to_rearm_cycles got=%0d exp=0", cycles); end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (cycles !== 16'd1) begin failures++; $display("FAIL to_rearm_count got=%0d exp=1", cycles); end
   endtask

   // Enters in RUN (left armed by test_timeout).
   task automatic test_reset_mid_run();
      a_tvalid = 1'b1; b_tvalid = 1'b1; a_tdata = 8'h5A; b_tdata = 8'h5A;
      repeat (2) @(posedge clk);
      @(negedge clk);
      a_tvalid = 1'b0; b_tvalid = 1'b0;
      checks++;
      if (matched !== 16'd1) begin failures++; $display("FAIL rstmid_pre_matched got=%0d exp=1", matched); end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (phase !== 3'd0) begin failures++; $display("FAIL rstmid_phase got=%0d exp=0", phase); end
      checks++;
      if ({mismatch, len_err, fail_a, fail_b, matched, cycles, a_tready, b_tready, a_step, b_step} !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs got m=%0d c=%0d rdy=%0b%0b step=%0b%0b exp all 0",
                  matched, cycles, a_tready, b_tready, a_step, b_step);
      end
      @(negedge clk);
      rst = 1'b0;
      a_src = '{8'hA1, 8'hB2, 8'hC3};
      b_src = '{8'hA1, 8'hB2, 8'hC3};
      do_start();
      run_streams(0, 0, 30, 1'b1);
      checks++;
      if (phase !== 3'd3) begin failures++; $display("FAIL rstmid_rerun_phase got=%0d exp=3", phase); end
      checks++;
      if ({mismatch, matched} !== {1'b0, 16'd3}) begin
         failures++; $display("FAIL rstmid_rerun got mm=%0b m=%0d exp mm=0 m=3", mismatch, matched);
      end
   endtask

   initial begin
      test_reset();
      test_identical();
      test_lag();
      test_data_mismatch();
      test_length();
      test_timeout();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
